// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch controller: line geometry and
// the controller state encoding.
package ifetch_pkg;

  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_BYTES     = 16;
  localparam int PTR_W          = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ifetch_line_buf.sv
// One fetched cache line: data, valid bit, line base address and the pointer
// to the next word handed to decode. Invalidate beats load beats advance.
module ifetch_line_buf
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inval,
  input  logic              adv,
  input  logic [LINE_W-1:0] line_in,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [PTR_W-1:0]  ptr_in,
  output logic              valid,
  output logic              last,
  output logic [31:0]       word,
  output logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] pc
);

  logic [WORDS_PER_LINE-1:0][31:0] line;
  logic [PTR_W-1:0]                ptr;

  // line register, valid bit and word pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line  <= '0;
      base  <= '0;
      ptr   <= '0;
      valid <= 1'b0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (load) begin
      line  <= line_in;
      base  <= base_in;
      ptr   <= ptr_in;
      valid <= 1'b1;
    end else if (adv) begin
      ptr <= ptr + 1'b1;
    end
  end

  assign word = line[ptr];
  assign last = (ptr == PTR_W'(WORDS_PER_LINE - 1));
  assign pc   = base + {{(ADDR_W-PTR_W-2){1'b0}}, ptr, 2'b00};

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: requests 128-bit lines from the i-cache,
// buffers them and streams 32-bit words to decode over valid/ready.
// Redirects flush buffered and in-flight lines.
// Build option IFETCH_PREFETCH_EN: second line buffer, next line is
// prefetched while the current one drains so sequential fetch has no bubble.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] Pc_in,
  output logic              Rd_en,
  input  logic [LINE_W-1:0] Dout,
  input  logic              Dout_valid,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc
);

`ifdef IFETCH_PREFETCH_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_BYTES);

  state_t           state;
  logic [PTR_W-1:0] fetch_wd;   // word offset of fetch_pc; line part lives in Pc_in
  logic             cur;        // buffer currently feeding decode
  logic             accept;

  logic [NBUF-1:0]             buf_load, buf_inval, buf_adv, buf_valid, buf_last;
  logic [NBUF-1:0][31:0]       buf_word;
  logic [NBUF-1:0][ADDR_W-1:0] buf_base, buf_pc;
  logic [PTR_W-1:0]            buf_ptr_in;
  logic [ADDR_W-1:0]           cur_base;
  logic                        cur_last;

  logic unused_bits;
  assign unused_bits = ^{redir_pc[1:0], buf_valid};

  assign accept   = instr_valid && instr_ready;
  assign cur_base = buf_base[cur];
  assign cur_last = buf_last[cur];

  assign instr_out = buf_word[cur];
  assign instr_pc  = buf_pc[cur];

`ifdef IFETCH_PREFETCH_EN
  logic pf_wait;                // prefetch request issued, response due this cycle
  logic pf_fill;
  assign pf_fill = pf_wait && Dout_valid;
`else
  assign cur = 1'b0;
`endif

  for (genvar b = 0; b < NBUF; b++) begin : g_buf
    ifetch_line_buf #(.ADDR_W(ADDR_W)) u_buf (
      .clk     (clk),
      .reset   (reset),
      .load    (buf_load[b]),
      .inval   (buf_inval[b]),
      .adv     (buf_adv[b]),
      .line_in (Dout),
      .base_in (Pc_in),
      .ptr_in  (buf_ptr_in),
      .valid   (buf_valid[b]),
      .last    (buf_last[b]),
      .word    (buf_word[b]),
      .base    (buf_base[b]),
      .pc      (buf_pc[b])
    );
  end

  // buffer strobes: redirect flushes everything and drops any response
  always_comb begin
    buf_load   = '0;
    buf_inval  = '0;
    buf_adv    = '0;
    buf_ptr_in = '0;
    if (redir_valid) begin
      buf_inval = '1;
    end else begin
      if (state == S_WAIT && Dout_valid) begin
        buf_load[cur] = 1'b1;
        buf_ptr_in    = fetch_wd;
      end
      if (accept) begin
        buf_adv[cur]   = 1'b1;
        buf_inval[cur] = cur_last;
      end
`ifdef IFETCH_PREFETCH_EN
      if (pf_fill) buf_load[~cur] = 1'b1;
`endif
    end
  end

  // fetch sequencing FSM with registered cache request and valid outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_REQ;
      Rd_en       <= 1'b0;
      Pc_in       <= RESET_PC & LINE_MASK;
      fetch_wd    <= RESET_PC[PTR_W+1:2];
      instr_valid <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
      cur         <= 1'b0;
      pf_wait     <= 1'b0;
`endif
    end else if (redir_valid) begin
      state       <= S_REQ;
      Rd_en       <= 1'b1;
      Pc_in       <= redir_pc & LINE_MASK;
      fetch_wd    <= redir_pc[PTR_W+1:2];
      instr_valid <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
      pf_wait     <= 1'b0;
`endif
    end else begin
      case (state)
        // straight out of reset Rd_en is still low: raise it before moving on
        S_REQ: begin
          if (Rd_en) begin
            state <= S_WAIT;
            Rd_en <= 1'b0;
          end else begin
            Rd_en <= 1'b1;
          end
        end
        S_WAIT: begin
          if (Dout_valid) begin
            state       <= S_DRAIN;
            instr_valid <= 1'b1;
          end else begin
            state <= S_REQ;
            Rd_en <= 1'b1;
          end
        end
        S_DRAIN: begin
`ifdef IFETCH_PREFETCH_EN
          if (accept && cur_last) begin
            pf_wait <= 1'b0;
            if (buf_valid[~cur] || pf_fill) begin
              cur <= ~cur;              // next line already in hand: no bubble
            end else if (Rd_en) begin
              state       <= S_WAIT;    // prefetch request is on the bus now
              Rd_en       <= 1'b0;
              fetch_wd    <= '0;
              instr_valid <= 1'b0;
            end else begin
              state       <= S_REQ;
              Rd_en       <= 1'b1;
              Pc_in       <= cur_base + LINE_STEP;
              fetch_wd    <= '0;
              instr_valid <= 1'b0;
            end
          end else if (Rd_en) begin
            Rd_en   <= 1'b0;
            pf_wait <= 1'b1;
          end else if (pf_wait) begin
            pf_wait <= 1'b0;
            Rd_en   <= !Dout_valid;     // missed response: re-issue same line
          end else if (!buf_valid[~cur]) begin
            Rd_en <= 1'b1;
            Pc_in <= cur_base + LINE_STEP;
          end
`else
          if (accept && cur_last) begin
            state       <= S_REQ;
            Rd_en       <= 1'b1;
            Pc_in       <= cur_base + LINE_STEP;
            fetch_wd    <= '0;
            instr_valid <= 1'b0;
          end
`endif
        end
        default: begin
          state       <= S_REQ;
          Rd_en       <= 1'b1;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl (default build). A cache model answers
// each request one cycle later from an address-hashed memory; a reference
// model tracks the expected instruction PC stream and the fetch timing rules.
module tb_ifetch_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  Pc_in;
  logic         Rd_en;
  logic [127:0] Dout = '0;
  logic         Dout_valid = 1'b0;
  logic         redir_valid = 1'b0;
  logic [31:0]  redir_pc = '0;
  logic         instr_valid;
  logic         instr_ready = 1'b0;
  logic [31:0]  instr_out;
  logic [31:0]  instr_pc;

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;

  // reference model state
  logic [31:0] exp_pc = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] redir_prev_pc = '0;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_out = '0;
  logic        rd_prev = 1'b0;
  logic        redir_prev = 1'b0;
  logic        hold_prev = 1'b0;

  always #5 clk = ~clk;

  ifetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .Pc_in       (Pc_in),
    .Rd_en       (Rd_en),
    .Dout        (Dout),
    .Dout_valid  (Dout_valid),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) * 32'h11) ^ (a & 32'hFFFF_FFF0);
  endfunction

  function automatic logic [127:0] line_data(input logic [31:0] a);
    logic [127:0] d;
    logic [31:0]  b;
    b = a & 32'hFFFF_FFF0;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = mem_word(b + 32'(4*k));
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: check this cycle's outputs, drive this cycle's inputs, advance model.
  task automatic tick(input logic rv, input logic [31:0] rpc, input logic rdy, input logic drop);
    @(negedge clk);
    if (!redir_prev) chk("rd_en_b2b", rd_prev & Rd_en, 1'b0);
    if (Rd_en) chk("pc_in_align", Pc_in[3:0], 4'h0);
    if (Rd_en || rd_prev) chk("iv_in_fetch", instr_valid, 1'b0);
    if (redir_prev) begin
      chk("redir_rd_en", Rd_en, 1'b1);
      chk("redir_pc_in", Pc_in, redir_prev_pc & 32'hFFFF_FFF0);
    end
    if (hold_prev) begin
      chk("hold_iv", instr_valid, 1'b1);
      chk("hold_pc", instr_pc, hold_pc);
      chk("hold_out", instr_out, hold_out);
    end
    if (instr_valid) begin
      chk("iv_pc", instr_pc, exp_pc);
      chk("iv_word", instr_out, mem_word(exp_pc));
    end
    Dout_valid  = rd_prev && !drop;
    Dout        = line_data(req_addr);
    redir_valid = rv;
    redir_pc    = rpc;
    instr_ready = rdy;
    if (instr_valid && rdy) begin
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    if (rv) exp_pc = rpc & 32'hFFFF_FFFC;
    hold_prev     = instr_valid && !rdy && !rv;
    hold_pc       = instr_pc;
    hold_out      = instr_out;
    redir_prev    = rv;
    redir_prev_pc = rpc;
    if (Rd_en) req_addr = Pc_in;
    rd_prev = Rd_en;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bub;
    int sel;
    logic [31:0] rpc;

    // reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_rd_en", Rd_en, 1'b0);
      chk("rst_pc_in", Pc_in, 32'h0);
      chk("rst_iv", instr_valid, 1'b0);
      chk("rst_out", instr_out, 32'h0);
      chk("rst_ipc", instr_pc, 32'h0);
    end
    reset = 1'b1;
    exp_pc = 32'h0;

    // first request right after release, then a sequential line
    tick(0, 0, 1, 0);
    chk("first_rd_en", Rd_en, 1'b1);
    chk("first_pc_in", Pc_in, 32'h0);
    tick(0, 0, 1, 0);
    chk("wait_iv", instr_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 1, 0);
      chk("seq_iv", instr_valid, 1'b1);
      chk("seq_pc", instr_pc, 32'(4*k));
      chk("seq_word", instr_out, 32'(17*k));
    end
    tick(0, 0, 1, 0);
    chk("seq_next_rd", Rd_en, 1'b1);
    chk("seq_next_pc", Pc_in, 32'h10);
    bub = 1;
    while (!instr_valid && bub < 8) begin
      tick(0, 0, 1, 0);
      if (!instr_valid) bub++;
    end
    chk("bubble", bub, 2);

    // unaligned redirect in cycle N
    tick(1, 32'h28, 0, 0);
    tick(0, 0, 1, 0);
    chk("redir28_rd", Rd_en, 1'b1);
    chk("redir28_pcin", Pc_in, 32'h20);
    tick(0, 0, 1, 0);
    chk("redir28_wait_iv", instr_valid, 1'b0);
    tick(0, 0, 1, 0);
    chk("redir28_n3_iv", instr_valid, 1'b1);
    chk("redir28_n3_pc", instr_pc, 32'h28);
    tick(0, 0, 1, 0);
    chk("redir28_n4_pc", instr_pc, 32'h2C);
    tick(0, 0, 1, 0);
    chk("redir28_next_rd", Rd_en, 1'b1);
    chk("redir28_next_pc", Pc_in, 32'h30);

    // backpressure mid-line
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    chk("bp_first_pc", instr_pc, 32'h30);
    for (int k = 0; k < 5; k++) begin
      tick(0, 0, 0, 0);
      chk("bp_pc", instr_pc, 32'h34);
      chk("bp_out", instr_out, mem_word(32'h34));
    end
    tick(0, 0, 1, 0);
    chk("bp_release_pc", instr_pc, 32'h34);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    chk("bp_last_pc", instr_pc, 32'h3C);

    // redirect in WAIT together with the response
    tick(0, 0, 1, 0);
    chk("wr_req_pc", Pc_in, 32'h40);
    tick(1, 32'h80, 1, 0);
    chk("wr_dv", Dout_valid, 1'b1);
    tick(0, 0, 1, 0);
    chk("wr_rd", Rd_en, 1'b1);
    chk("wr_pcin", Pc_in, 32'h80);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    chk("wr_iv", instr_valid, 1'b1);
    chk("wr_pc", instr_pc, 32'h80);

    // address wrap and a withheld response
    tick(1, 32'hFFFF_FFF8, 0, 0);
    tick(0, 0, 1, 0);
    chk("wrap_pcin", Pc_in, 32'hFFFF_FFF0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    chk("wrap_pc_f8", instr_pc, 32'hFFFF_FFF8);
    tick(0, 0, 1, 0);
    chk("wrap_pc_fc", instr_pc, 32'hFFFF_FFFC);
    tick(0, 0, 1, 0);
    chk("wrap_next_rd", Rd_en, 1'b1);
    chk("wrap_next_pc", Pc_in, 32'h0);
    tick(0, 0, 1, 1);
    chk("miss_iv", instr_valid, 1'b0);
    tick(0, 0, 1, 0);
    chk("miss_rereq_rd", Rd_en, 1'b1);
    chk("miss_rereq_pc", Pc_in, 32'h0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    chk("miss_iv_pc", instr_pc, 32'h0);
    tick(0, 0, 1, 0);

    // asynchronous reset mid-line
    #2 reset = 1'b0;
    #1;
    chk("arst_rd_en", Rd_en, 1'b0);
    chk("arst_iv", instr_valid, 1'b0);
    chk("arst_pc_in", Pc_in, 32'h0);
    chk("arst_ipc", instr_pc, 32'h0);
    chk("arst_out", instr_out, 32'h0);
    Dout_valid  = 1'b0;
    redir_valid = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    exp_pc     = 32'h0;
    rd_prev    = 1'b0;
    redir_prev = 1'b0;
    hold_prev  = 1'b0;
    n_acc      = 0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      rpc = $urandom;
      else if (sel == 1) rpc = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
      else               rpc = 32'($urandom_range(0, 255));
      tick($urandom_range(0, 99) < 4, rpc, $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 15);
    end
    chk("rand_progress", n_acc > 200, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
